// File: rtl/tpu_result_drain.sv
// tpu_result_drain: captures cast-array output rows into a small row buffer and
// drains each row as LANES-wide beats on a valid/ready stream with byte addresses.
// Back-pressures the cast pipeline through upstream_en, reserving a slot for the
// row that the cast stage may emit one cycle after its enable.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, base_addr, num_rows         job launch (ignored while busy)
//   busy, done                         job status, done is a 1-cycle pulse
//   upstream_en                        cast-array enable (from registers only)
//   row_in, row_valid, row_sat         cast row, its valid, per-element saturation
//   m_valid, m_ready, m_data, m_addr,  output beat stream
//   m_last
//   sat_count                          saturated elements captured this job
//
// Optional feature: define TPU_DRAIN_SAT_COUNT_EN to enable sat_count; otherwise
// sat_count is tied to 0 and row_sat is unused.
module tpu_result_drain #(
    parameter int unsigned ARRAY_SIZE = 64,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [15:0]                      num_rows,
    output logic                             busy,
    output logic                             done,
    output logic                             upstream_en,
    input  logic [ARRAY_SIZE*OUT_WIDTH-1:0]  row_in,
    input  logic                             row_valid,
    input  logic [ARRAY_SIZE-1:0]            row_sat,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [LANES*OUT_WIDTH-1:0]       m_data,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    output logic                             m_last,
    output logic [15:0]                      sat_count
);

    localparam int unsigned BEATS      = ARRAY_SIZE / LANES;
    localparam int unsigned ROW_BITS   = ARRAY_SIZE * OUT_WIDTH;
    localparam int unsigned BEAT_BITS  = LANES * OUT_WIDTH;
    localparam int unsigned BEAT_BYTES = BEAT_BITS / 8;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [15:0]             rows_in_q, rows_in_d, rows_out_q, rows_out_d;
    logic [15:0]             num_rows_q, num_rows_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    en_q, en_d;
    logic [ROW_BITS-1:0]     mem_q [DEPTH];
    logic [ROW_BITS-1:0]     head_row_c;
    logic                    push_c, hs_c, pop_c, start_ok_c;
    logic [ADDR_WIDTH-1:0]   beat_idx_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status, enable and handshake terms, all decoded from registers
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        // Count the in-flight row (en_q) against both buffer room and job length
        upstream_en = (state_q == ST_RUN)
                   && ((32'(count_q) + 32'(en_q)) < DEPTH)
                   && ((17'(rows_in_q) + 17'(en_q)) < 17'(num_rows_q));
        m_valid     = (state_q == ST_RUN) && (count_q != '0);
        m_last      = m_valid && (beat_q == BEAT_W'(BEATS - 1));
        push_c      = row_valid && en_q;
        hs_c        = m_valid && m_ready;
        pop_c       = hs_c && (beat_q == BEAT_W'(BEATS - 1));
        start_ok_c  = start && (state_q == ST_IDLE);
    end

    // Next-state and bookkeeping
    always_comb begin
        state_d    = state_q;
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_d     = beat_q;
        rows_in_d  = rows_in_q;
        rows_out_d = rows_out_q;
        num_rows_d = num_rows_q;
        base_d     = base_q;
        en_d       = upstream_en;

        if (push_c) begin
            wr_ptr_d  = ptr_inc(wr_ptr_q);
            rows_in_d = rows_in_q + 16'd1;
        end
        if (hs_c) begin
            beat_d = pop_c ? '0 : beat_q + BEAT_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            rows_out_d = rows_out_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    num_rows_d = num_rows;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                    state_d    = (num_rows == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop_c && ((17'(rows_out_q) + 17'd1) == 17'(num_rows_q))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            num_rows_q <= '0;
            base_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            rows_in_q  <= rows_in_d;
            rows_out_q <= rows_out_d;
            num_rows_q <= num_rows_d;
            base_q     <= base_d;
            en_q       <= en_d;
        end
    end

    // Row storage; contents are only observed while m_valid, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= row_in;
        end
    end

    // Beat select from the head row; zero when no beat is offered
    always_comb begin
        head_row_c = mem_q[rd_ptr_q];
        m_data     = '0;
        if (m_valid) begin
            for (int b = 0; b < int'(BEATS); b++) begin
                if (beat_q == BEAT_W'(b)) begin
                    m_data = head_row_c[b*BEAT_BITS +: BEAT_BITS];
                end
            end
        end
    end

    // Byte address of the current beat within the job
    always_comb begin
        beat_idx_c = ADDR_WIDTH'(rows_out_q) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(beat_q);
        m_addr     = base_q + beat_idx_c * ADDR_WIDTH'(BEAT_BYTES);
    end

`ifdef TPU_DRAIN_SAT_COUNT_EN
    logic [15:0] sat_q, sat_d;
    logic [15:0] row_pop_c;
    logic [16:0] sat_sum_c;

    // Saturating popcount accumulator, cleared on an accepted start
    always_comb begin
        row_pop_c = '0;
        for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            row_pop_c = row_pop_c + 16'(row_sat[i]);
        end
        sat_sum_c = 17'(sat_q) + 17'(row_pop_c);
        sat_d     = sat_q;
        if (start_ok_c) begin
            sat_d = '0;
        end else if (push_c) begin
            sat_d = sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_count = sat_q;
`else
    logic unused_sat_c;
    assign unused_sat_c = ^{row_sat, start_ok_c};
    assign sat_count    = '0;
`endif

endmodule
